// File: rtl/div_seq_if.sv
// div_seq_if: start/operand/result bundle between the datapath sequencer and div_seq.
interface div_seq_if;
  logic        ini;
  logic [31:0] A;
  logic [15:0] B;
  logic [31:0] quociente;
  logic [15:0] resto;
  logic        pronto;
  logic        ocupado;
  logic        div_zero;

  // Sequencer side: issues ini with operands, polls pronto/ocupado.
  modport master (
    output ini, A, B,
    input  quociente, resto, pronto, ocupado, div_zero
  );

  // Divider side.
  modport slave (
    input  ini, A, B,
    output quociente, resto, pronto, ocupado, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential 32/16 radix-2 restoring divider, one quotient bit per cycle.
// DIV_SIGNED_EN selects two's-complement operands; undefined gives unsigned operation.
module div_seq (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, ABS, ITER, FIX} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   a_r, a_n;
  logic [BW-1:0]   b_r, b_n;
  logic [AW-1:0]   dq, dq_n;
  logic [BW-1:0]   pr, pr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   q_r, q_n;
  logic [BW-1:0]   r_r, r_n;
  logic            pronto_r, pronto_n;
  logic            ocupado_r, ocupado_n;
  logic            dz_r, dz_n;
  logic [BW:0]     pr_sh;
  logic [AW-1:0]   dq_sh;
`ifdef DIV_SIGNED_EN
  logic            sign_q, sign_q_n;
  logic            sign_r, sign_r_n;
`endif

  assign bus.quociente = q_r;
  assign bus.resto     = r_r;
  assign bus.pronto    = pronto_r;
  assign bus.ocupado   = ocupado_r;
  assign bus.div_zero  = dz_r;

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      dq        <= '0;
      pr        <= '0;
      cnt       <= '0;
      q_r       <= '0;
      r_r       <= '0;
      pronto_r  <= 1'b0;
      ocupado_r <= 1'b0;
      dz_r      <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      a_r       <= a_n;
      b_r       <= b_n;
      dq        <= dq_n;
      pr        <= pr_n;
      cnt       <= cnt_n;
      q_r       <= q_n;
      r_r       <= r_n;
      pronto_r  <= pronto_n;
      ocupado_r <= ocupado_n;
      dz_r      <= dz_n;
`ifdef DIV_SIGNED_EN
      sign_q    <= sign_q_n;
      sign_r    <= sign_r_n;
`endif
    end
  end

  // Next-state and datapath: latch, take magnitudes, iterate, apply signs.
  always_comb begin
    state_n  = state;
    a_n      = a_r;
    b_n      = b_r;
    dq_n     = dq;
    pr_n     = pr;
    cnt_n    = cnt;
    q_n      = q_r;
    r_n      = r_r;
    pronto_n = 1'b0;
    dz_n     = dz_r;
`ifdef DIV_SIGNED_EN
    sign_q_n = sign_q;
    sign_r_n = sign_r;
`endif
    pr_sh    = {pr, dq[AW-1]};
    dq_sh    = {dq[AW-2:0], 1'b0};

    case (state)
      IDLE: begin
        if (bus.ini) begin
          a_n     = bus.A;
          b_n     = bus.B;
          dz_n    = 1'b0;
          state_n = ABS;
        end
      end
      ABS: begin
        if (b_r == '0) begin
`ifdef DIV_SIGNED_EN
          q_n = a_r[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
          q_n = 32'hFFFF_FFFF;
`endif
          r_n      = a_r[BW-1:0];
          dz_n     = 1'b1;
          pronto_n = 1'b1;
          state_n  = IDLE;
        end else begin
`ifdef DIV_SIGNED_EN
          sign_q_n = a_r[AW-1] ^ b_r[BW-1];
          sign_r_n = a_r[AW-1];
          dq_n     = a_r[AW-1] ? AW'(-a_r) : a_r;
          b_n      = b_r[BW-1] ? BW'(-b_r) : b_r;
`else
          dq_n     = a_r;
`endif
          pr_n     = '0;
          cnt_n    = CW'(AW - 1);
          state_n  = ITER;
        end
      end
      ITER: begin
        // Trial subtract against the shifted partial remainder; it always fits 17 bits.
        if (pr_sh >= {1'b0, b_r}) begin
          pr_n = BW'(pr_sh - {1'b0, b_r});
          dq_n = {dq_sh[AW-1:1], 1'b1};
        end else begin
          pr_n = pr_sh[BW-1:0];
          dq_n = dq_sh;
        end
        cnt_n = cnt - CW'(1);
        if (cnt == '0) state_n = FIX;
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        q_n = sign_q ? AW'(-dq) : dq;
        r_n = sign_r ? BW'(-pr) : pr;
`else
        q_n = dq;
        r_n = pr;
`endif
        pronto_n = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    ocupado_n = (state_n != IDLE);
  end

endmodule
